// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller beside the ID stage: per-operand forwarding selects,
// load-use stall sequencing, taken-branch IF/ID flush and a saturating stall counter.
module hazard_ctrl_unit #(
   parameter int AW       = 4,
   parameter int NSRC     = 3,
   parameter int LOAD_LAT = 1,
   parameter int CW       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC*AW-1:0]   id_src,
   input  logic [NSRC-1:0]      id_src_valid,
   input  logic [AW-1:0]        ex_rd,
   input  logic                 ex_rf_en,
   input  logic                 ex_load,
   input  logic [AW-1:0]        mem_rd,
   input  logic                 mem_rf_en,
   input  logic [AW-1:0]        wb_rd,
   input  logic                 wb_rf_en,
   input  logic                 branch_taken,
   output logic [2*NSRC-1:0]    fwd_sel,
   output logic                 nop_sel,
   output logic                 le_pc,
   output logic                 le_if_id,
   output logic                 flush_if_id,
   output logic                 stall_active,
   output logic [CW-1:0]        stall_count
);

   localparam int RW = $clog2(LOAD_LAT + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t          state, state_next;
   logic [RW-1:0]   remaining, remaining_next;
   logic [CW-1:0]   count_next;
   logic [2*NSRC-1:0] fwd_raw;
   logic            detect;
   logic            stall;

   // Forwarding selects and load-use detection share the same operand scan.
   always_comb begin
      fwd_raw = '0;
      detect  = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (id_src_valid[i]) begin
            if (ex_rf_en && (id_src[i*AW +: AW] == ex_rd)) begin
               fwd_raw[2*i +: 2] = 2'b01;
               if (ex_load) begin
                  detect = 1'b1;
               end
            end else if (mem_rf_en && (id_src[i*AW +: AW] == mem_rd)) begin
               fwd_raw[2*i +: 2] = 2'b10;
            end else if (wb_rf_en && (id_src[i*AW +: AW] == wb_rd)) begin
               fwd_raw[2*i +: 2] = 2'b11;
            end
         end
      end
   end

   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      case (state)
         IDLE: begin
            if (detect && (LOAD_LAT > 1)) begin
               state_next     = STALL;
               remaining_next = RW'(LOAD_LAT - 1);
            end
         end
         STALL: begin
            // Detects in the last stall cycle are ignored here and re-evaluated from IDLE.
            if (remaining <= RW'(1)) begin
               state_next     = IDLE;
               remaining_next = '0;
            end else begin
               remaining_next = remaining - RW'(1);
            end
         end
         default: begin
            state_next     = IDLE;
            remaining_next = '0;
         end
      endcase
   end

   always_comb begin
      stall      = detect || (state == STALL);
      count_next = stall_count;
      if (stall && (stall_count != '1)) begin
         count_next = stall_count + CW'(1);
      end
   end

   always_comb begin
      fwd_sel      = fwd_raw;
      nop_sel      = stall;
      le_pc        = ~stall;
      le_if_id     = ~stall;
      flush_if_id  = branch_taken & ~stall;
      stall_active = (state == STALL);
      if (reset) begin
         fwd_sel      = '0;
         nop_sel      = 1'b0;
         le_pc        = 1'b1;
         le_if_id     = 1'b1;
         flush_if_id  = 1'b0;
         stall_active = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         remaining   <= '0;
         stall_count <= '0;
      end else begin
         state       <= state_next;
         remaining   <= remaining_next;
         stall_count <= count_next;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: four instances (LOAD_LAT 1..4, last with CW=2) on shared
// stimulus, each compared every cycle against a stall-budget reference model.
module tb_hazard_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] id_src;
   logic [2:0]  id_src_valid;
   logic [3:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_rf_en, ex_load, mem_rf_en, wb_rf_en, branch_taken;

   logic [5:0]  fs [4];
   logic        nop [4];
   logic        lpc [4];
   logic        lif [4];
   logic        fl  [4];
   logic        sa  [4];
   logic [15:0] sc  [4];

   int total = 0;
   int bad   = 0;

   int left [4];
   int cnt  [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int L = g + 1;
      localparam int C = (g == 3) ? 2 : 16;
      logic [C-1:0] cnt_w;
      hazard_ctrl_unit #(.AW(4), .NSRC(3), .LOAD_LAT(L), .CW(C)) u_dut (
         .clk          (clk),
         .reset        (reset),
         .id_src       (id_src),
         .id_src_valid (id_src_valid),
         .ex_rd        (ex_rd),
         .ex_rf_en     (ex_rf_en),
         .ex_load      (ex_load),
         .mem_rd       (mem_rd),
         .mem_rf_en    (mem_rf_en),
         .wb_rd        (wb_rd),
         .wb_rf_en     (wb_rf_en),
         .branch_taken (branch_taken),
         .fwd_sel      (fs[g]),
         .nop_sel      (nop[g]),
         .le_pc        (lpc[g]),
         .le_if_id     (lif[g]),
         .flush_if_id  (fl[g]),
         .stall_active (sa[g]),
         .stall_count  (cnt_w)
      );
      assign sc[g] = 16'(cnt_w);
   end

   function automatic int lat_of(input int k);
      return k + 1;
   endfunction

   function automatic int cmax_of(input int k);
      return (k == 3) ? 3 : 65535;
   endfunction

   function automatic logic [5:0] ref_fwd();
      logic [5:0] r;
      logic [3:0] s;
      r = '0;
      for (int op = 0; op < 3; op++) begin
         s = id_src[op*4 +: 4];
         if (!id_src_valid[op])                r[op*2 +: 2] = 2'd0;
         else if (ex_rf_en  && s == ex_rd)     r[op*2 +: 2] = 2'd1;
         else if (mem_rf_en && s == mem_rd)    r[op*2 +: 2] = 2'd2;
         else if (wb_rf_en  && s == wb_rd)     r[op*2 +: 2] = 2'd3;
         else                                  r[op*2 +: 2] = 2'd0;
      end
      return r;
   endfunction

   function automatic bit ref_detect();
      bit hit;
      hit = 1'b0;
      for (int op = 0; op < 3; op++)
         if (id_src_valid[op] && id_src[op*4 +: 4] == ex_rd) hit = 1'b1;
      return ex_load && ex_rf_en && hit;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] got=%0h want=%0h", tag, k, obs, exp);
      end
   endtask

   // One cycle: compare at the falling edge, then advance the model across the rising edge.
   task automatic step();
      bit det, stl;
      @(negedge clk);
      det = ref_detect();
      for (int k = 0; k < 4; k++) begin
         stl = !reset && (det || left[k] > 0);
         chk("fwd_sel",      k, 32'(fs[k]),  reset ? 32'd0 : 32'(ref_fwd()));
         chk("nop_sel",      k, 32'(nop[k]), 32'(stl));
         chk("le_pc",        k, 32'(lpc[k]), 32'(!stl));
         chk("le_if_id",     k, 32'(lif[k]), 32'(!stl));
         chk("flush_if_id",  k, 32'(fl[k]),  32'(!reset && branch_taken && !stl));
         chk("stall_active", k, 32'(sa[k]),  32'(!reset && left[k] > 0));
         chk("stall_count",  k, 32'(sc[k]),  32'(cnt[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (reset) begin
            left[k] = 0;
            cnt[k]  = 0;
         end else begin
            stl = det || left[k] > 0;
            if (left[k] > 0)  left[k] = left[k] - 1;
            else if (det)     left[k] = lat_of(k) - 1;
            if (stl && cnt[k] < cmax_of(k)) cnt[k] = cnt[k] + 1;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      id_src = '0; id_src_valid = '0;
      ex_rd = '0; mem_rd = '0; wb_rd = '0;
      ex_rf_en = 1'b0; ex_load = 1'b0; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
      branch_taken = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin left[k] = 0; cnt[k] = 0; end
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();

      // Forwarding priority EX > MEM > WB on operand 0
      id_src = 12'h005; id_src_valid = 3'b001;
      ex_rd = 4'd5; mem_rd = 4'd5; wb_rd = 4'd5;
      ex_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
      #1 chk("prio_ex", 0, 32'(fs[0][1:0]), 32'd1);
      step();
      ex_rf_en = 1'b0;
      #1 chk("prio_mem", 0, 32'(fs[0][1:0]), 32'd2);
      step();
      mem_rf_en = 1'b0;
      #1 chk("prio_wb", 0, 32'(fs[0][1:0]), 32'd3);
      step();
      wb_rf_en = 1'b0;
      #1 chk("prio_rf", 0, 32'(fs[0][1:0]), 32'd0);
      step();

      // Invalid operand neither forwards nor causes a load-use stall
      id_src = 12'h030; id_src_valid = 3'b000;
      ex_rd = 4'd3; ex_rf_en = 1'b1; ex_load = 1'b1;
      #1 chk("gate_fwd", 0, 32'(fs[0][3:2]), 32'd0);
      chk("gate_nop", 3, 32'(nop[3]), 32'd0);
      step();

      // Single load-use pulse on operand 2
      id_src = 12'h700; id_src_valid = 3'b100; ex_rd = 4'd7;
      step();
      idle_inputs();
      for (int c = 0; c < 5; c++) step();
      chk("lu_cnt_l1", 0, 32'(sc[0]), 32'd1);
      chk("lu_cnt_l2", 1, 32'(sc[1]), 32'd2);
      chk("lu_cnt_l3", 2, 32'(sc[2]), 32'd3);
      chk("lu_cnt_sat", 3, 32'(sc[3]), 32'd3);

      // Branch taken together with a detect, branch held for several cycles
      reset = 1'b1; step(); reset = 1'b0;
      id_src = 12'h009; id_src_valid = 3'b001; ex_rd = 4'd9;
      ex_rf_en = 1'b1; ex_load = 1'b1; branch_taken = 1'b1;
      step();
      ex_load = 1'b0;
      for (int c = 0; c < 4; c++) step();
      branch_taken = 1'b0;

      // Reset during the stall of the LOAD_LAT=4 instance
      ex_load = 1'b1;
      step();
      ex_load = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1 chk("rst_abort_sa", 3, 32'(sa[3]), 32'd0);
      chk("rst_abort_cnt", 3, 32'(sc[3]), 32'd0);
      chk("rst_abort_pc", 3, 32'(lpc[3]), 32'd1);
      step();

      // Back-to-back load-use pulses saturate the CW=2 counter
      id_src = 12'h00a; id_src_valid = 3'b001; ex_rd = 4'ha; ex_rf_en = 1'b1; ex_load = 1'b1;
      for (int c = 0; c < 5; c++) step();
      idle_inputs();
      step();
      chk("sat_hold", 3, 32'(sc[3]), 32'd3);

      // Randomised traffic, biased so EX often matches a source operand
      for (int c = 0; c < 600; c++) begin
         id_src       = 12'($urandom);
         id_src_valid = 3'($urandom_range(0, 7));
         mem_rd       = 4'($urandom_range(0, 15));
         wb_rd        = 4'($urandom_range(0, 15));
         ex_rd        = ($urandom_range(0, 1) == 0) ? id_src[$urandom_range(0, 2)*4 +: 4]
                                                    : 4'($urandom_range(0, 15));
         ex_rf_en     = ($urandom_range(0, 3) != 0);
         ex_load      = ($urandom_range(0, 1) == 0);
         mem_rf_en    = ($urandom_range(0, 1) == 0);
         wb_rf_en     = ($urandom_range(0, 1) == 0);
         branch_taken = ($urandom_range(0, 2) == 0);
         reset        = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised hazard/forwarding controller for the pipelined core, placed beside the ID stage. It handles N source operands and generates per-operand forwarding mux selects with EX > MEM > WB priority. A small FSM holds the front end for a configurable load-use latency, and IF/ID is flushed for one cycle on a taken branch. A saturating stall-cycle counter is exposed for performance monitoring.

Parameters:
AW, 4, register address width
NSRC, 3, number of ID source operands (Rn, Rm, Rd order: operand 0 = Rn)
LOAD_LAT, 1, load-use stall length in cycles (>=1; 1 = single bubble)
CW, 16, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
id_src  in  NSRC*AW  ID source register numbers, operand i at [i*AW +: AW]
id_src_valid  in  NSRC  operand i actually read by the ID instruction
ex_rd  in  AW  destination register in EX
ex_rf_en  in  1  EX instruction writes the register file
ex_load  in  1  EX instruction is a load
mem_rd  in  AW  destination register in MEM
mem_rf_en  in  1  MEM instruction writes the register file
wb_rd  in  AW  destination register in WB
wb_rf_en  in  1  WB instruction writes the register file
branch_taken  in  1  ID-resolved taken branch this cycle
fwd_sel  out  2*NSRC  per-operand select: 00 RF, 01 EX, 10 MEM, 11 WB
nop_sel  out  1  insert NOP into ID/EX control
le_pc  out  1  PC load enable
le_if_id  out  1  IF/ID register load enable
flush_if_id  out  1  clear IF/ID register this cycle
stall_active  out  1  FSM in STALL state
stall_count  out  CW  saturating count of stalled cycles

Behaviour:
- Forwarding is combinational. For each operand i: if id_src_valid[i]=0 then 00. Else the first match wins: ex_rf_en & src==ex_rd -> 01; mem_rf_en & src==mem_rd -> 10; wb_rf_en & src==wb_rd -> 11; otherwise 00.
- Load-use detect (comb) = ex_load & ex_rf_en & any valid operand matching ex_rd.
- FSM states: IDLE, STALL. Counter remaining[ceil(log2(LOAD_LAT+1))-1:0].
- IDLE: if detect, stall outputs assert this cycle. If LOAD_LAT>1, go to STALL with remaining=LOAD_LAT-1. If LOAD_LAT=1, stay in IDLE; the single bubble is the detect cycle.
- STALL: stall outputs asserted unconditionally. remaining decrements each cycle. At remaining==1, return to IDLE next edge. Total stalled cycles per load-use = LOAD_LAT.
- Stall outputs: nop_sel=1, le_pc=0, le_if_id=0. Otherwise nop_sel=0, le_pc=1, le_if_id=1.
- flush_if_id = branch_taken & ~stall, where stall = detect | stall_active. While stalling, the branch is held in ID and re-presented; the flush occurs the cycle the stall releases.
- A new detect in the final STALL cycle re-enters the stall sequence: it is evaluated on the IDLE path the following cycle.
- stall_count increments by 1 on every clock edge where stall=1. It saturates at 2^CW-1 and never wraps.
- Reset, at the edge: state=IDLE, remaining=0, stall_count=0.
- While reset=1, outputs are forced combinationally: nop_sel=0, le_pc=1, le_if_id=1, flush_if_id=0, stall_active=0, fwd_sel=0.
- Reset asserted mid-STALL aborts the stall; the stall is not resumed.
- Zero latency through all combinational paths. Only state, remaining and stall_count are registered.

Test Plan:
- Priority: id_src op0=5 valid; ex_rd=5, mem_rd=5, wb_rd=5, all rf_en=1 -> fwd_sel[1:0]=01. Drop ex_rf_en -> 10. Drop mem_rf_en -> 11. Drop wb_rf_en -> 00.
- Valid gating: op1=3 with id_src_valid[1]=0, ex_rd=3, ex_rf_en=1 -> fwd_sel[3:2]=00. With ex_load=1, no stall.
- Load-use, LOAD_LAT=1: ex_load=1, ex_rd=7, op2=7 valid -> exactly 1 cycle of nop_sel=1, le_pc=0, le_if_id=0. stall_count goes 0 -> 1. stall_active stays 0.
- Load-use, LOAD_LAT=3: single detect pulse -> stall held 3 consecutive cycles, stall_active=1 for cycles 2-3, stall_count=3, then le_pc=1.
- Branch during stall, LOAD_LAT=2: detect and branch_taken together -> flush_if_id=0 for 2 cycles. branch_taken still high in cycle 3 -> flush_if_id=1.
- Reset mid-STALL (LOAD_LAT=4, reset at cycle 2) -> next cycle stall_active=0, stall_count=0, le_pc=1. Also CW=2 with 5 stall cycles -> stall_count holds at 3.
